// File: rtl/gpio_pkg.sv
// Shared types and sizing helpers for the GPIO output hold port.
package gpio_pkg;

  typedef enum logic [1:0] {
    PIN_IDLE = 2'd0,
    PIN_HOLD = 2'd1,
    PIN_PEND = 2'd2
  } pin_state_t;

  // Clock cycles a pin must hold a new level; 0 means the hold is bypassed.
  function automatic int unsigned hold_cycles(input int unsigned freq_hz,
                                               input int unsigned hold_ms);
    return (freq_hz / 32'd1000) * hold_ms;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 32'd1) ? 32'd1 : $clog2(cycles + 32'd1);
  endfunction

endpackage

// File: rtl/gpio_hold_pin.sv
// Single-pin output hold filter: every applied edge persists for HOLD_CYCLES
// clocks, and requests made during the hold coalesce to the latest value.
module gpio_hold_pin
  import gpio_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter logic        RESET_BIT   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_i,
  output logic       pin_o,
  output logic       busy_o,
  output logic       pend_o,
  output pin_state_t state_o
);

  localparam int unsigned   CW       = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          pin_q;
  logic [CW-1:0] cnt_q;
  pin_state_t    state_q;
  logic          busy_q;
  logic          pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_q   <= RESET_BIT;
      cnt_q   <= '0;
      state_q <= PIN_IDLE;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        PIN_IDLE: begin
          if (req_i != pin_q) begin
            pin_q   <= req_i;
            cnt_q   <= CNT_LOAD;
            state_q <= PIN_HOLD;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
        PIN_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= PIN_IDLE;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (req_i != pin_q) begin
              state_q <= PIN_PEND;
              pend_q  <= 1'b1;
            end
          end
        end
        PIN_PEND: begin
          // Latest request wins; a request that bounced back is dropped.
          if (cnt_q == '0) begin
            if (req_i != pin_q) begin
              pin_q   <= req_i;
              cnt_q   <= CNT_LOAD;
              state_q <= PIN_HOLD;
              pend_q  <= 1'b0;
            end else begin
              state_q <= PIN_IDLE;
              busy_q  <= 1'b0;
              pend_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= PIN_IDLE;
          busy_q  <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pin_o   = pin_q;
  assign busy_o  = busy_q;
  assign pend_o  = pend_q;
  assign state_o = state_q;

endmodule

// File: rtl/gpio_hold_port.sv
// GPIO output conditioning between the register block and the pad buffers.
// Define GPIO_HOLD_STATUS_EN to add the hold_busy / hold_pend status outputs.
module gpio_hold_port
  import gpio_pkg::*;
#(
  parameter int unsigned         C_FREQ_CLK_HZ = 100000000,
  parameter int unsigned         C_DWIDTH      = 32,
  parameter int unsigned         C_TRIMODE     = 1,
  parameter int unsigned         C_HOLD_TIME   = 12,
  parameter logic [C_DWIDTH-1:0] C_RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [C_DWIDTH-1:0] l_gpio_o,
  input  logic [C_DWIDTH-1:0] l_gpio_t,
  output logic [C_DWIDTH-1:0] r_gpio_o,
  output logic [C_DWIDTH-1:0] r_gpio_t
`ifdef GPIO_HOLD_STATUS_EN
  ,
  output logic [C_DWIDTH-1:0] hold_busy,
  output logic [C_DWIDTH-1:0] hold_pend
`endif
);

  localparam int unsigned HOLD_CYCLES = hold_cycles(C_FREQ_CLK_HZ, C_HOLD_TIME);

  generate
    if (C_TRIMODE == 0) begin : g_input_only
      assign r_gpio_o = '0;
      assign r_gpio_t = '1;
`ifdef GPIO_HOLD_STATUS_EN
      assign hold_busy = '0;
      assign hold_pend = '0;
`endif
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset_n, l_gpio_o, l_gpio_t};
    end else begin : g_bidir
      // Tristate enables are registered only; the hold keeps running underneath.
      logic [C_DWIDTH-1:0] t_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) t_q <= '1;
        else          t_q <= l_gpio_t;
      end
      assign r_gpio_t = t_q;

      if (HOLD_CYCLES == 0) begin : g_bypass
        logic [C_DWIDTH-1:0] o_q;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) o_q <= C_RESET_VALUE;
          else          o_q <= l_gpio_o;
        end
        assign r_gpio_o = o_q;
`ifdef GPIO_HOLD_STATUS_EN
        assign hold_busy = '0;
        assign hold_pend = '0;
`endif
      end else begin : g_hold
        for (genvar i = 0; i < int'(C_DWIDTH); i++) begin : g_pin
          logic       pin;
          logic       busy;
          logic       pend;
          pin_state_t st;

          gpio_hold_pin #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .RESET_BIT   (C_RESET_VALUE[i])
          ) u_pin (
            .clk     (clk),
            .reset_n (reset_n),
            .req_i   (l_gpio_o[i]),
            .pin_o   (pin),
            .busy_o  (busy),
            .pend_o  (pend),
            .state_o (st)
          );

          assign r_gpio_o[i] = pin;
`ifdef GPIO_HOLD_STATUS_EN
          assign hold_busy[i] = busy;
          assign hold_pend[i] = pend;
          logic unused_state;
          assign unused_state = ^st;
`else
          logic unused_status;
          assign unused_status = ^{st, busy, pend};
`endif
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_gpio_hold_port.sv
// Bench for gpio_hold_port: directed hold scenarios followed by random traffic,
// each edge scored against a timestamp-based model of the minimum-hold rule.
`timescale 1ns/1ps
module tb_gpio_hold_port;

  localparam int          W     = 4;
  localparam int          H     = 1000;
  localparam logic [W-1:0] RST_V = 4'b0101;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] l_o;
  logic [W-1:0] l_t;
  logic [W-1:0] r_o;
  logic [W-1:0] r_t;
`ifdef GPIO_HOLD_STATUS_EN
  logic [W-1:0] busy;
  logic [W-1:0] pend;
`endif

  gpio_hold_port #(
    .C_FREQ_CLK_HZ (1000000),
    .C_DWIDTH      (W),
    .C_TRIMODE     (1),
    .C_HOLD_TIME   (1),
    .C_RESET_VALUE (RST_V)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .l_gpio_o (l_o),
    .l_gpio_t (l_t),
    .r_gpio_o (r_o),
    .r_gpio_t (r_t)
`ifdef GPIO_HOLD_STATUS_EN
    ,
    .hold_busy (busy),
    .hold_pend (pend)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  // Reference model: pin level, edge index of its last change, and whether a
  // differing request was seen inside the hold window that followed it.
  logic [W-1:0] m_o;
  logic [W-1:0] m_t;
  int           m_last [W];
  bit           m_live [W];
  bit           m_saw  [W];
  int           edge_n = 0;

  task automatic model_reset();
    m_o = RST_V;
    m_t = '1;
    for (int i = 0; i < W; i++) begin
      m_last[i] = 0;
      m_live[i] = 1'b0;
      m_saw[i]  = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] req, input logic [W-1:0] treq, input int n);
    for (int i = 0; i < W; i++) begin
      if (!m_live[i] || n > m_last[i] + H) begin
        if (req[i] != m_o[i]) begin
          m_o[i] = req[i]; m_last[i] = n; m_live[i] = 1'b1; m_saw[i] = 1'b0;
        end
      end else if (n < m_last[i] + H) begin
        if (req[i] != m_o[i]) m_saw[i] = 1'b1;
      end else begin
        if (m_saw[i] && req[i] != m_o[i]) begin
          m_o[i] = req[i]; m_last[i] = n;
        end
        m_saw[i] = 1'b0;
      end
    end
    m_t = treq;
  endtask

  function automatic logic [15:0] model_out(input int n);
    logic [W-1:0] b;
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) begin
      b[i] = m_live[i] && (n < m_last[i] + H);
      p[i] = b[i] && m_saw[i];
    end
    return {p, b, m_t, m_o};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // driver: one clock edge, scored against the model
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge(l_o, l_t, edge_n);
    exp_q.push_back(model_out(edge_n));
    edge_n++;
    #1;
    e = exp_q.pop_front();
    check("edge_o", r_o, e[3:0]);
    check("edge_t", r_t, e[7:4]);
`ifdef GPIO_HOLD_STATUS_EN
    check("edge_busy", busy, e[11:8]);
    check("edge_pend", pend, e[15:12]);
`endif
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset_n = 1'b1;
    l_o     = 4'b1010;
    l_t     = 4'b0000;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_o", r_o, 4'b0101);
    check("rst_t", r_t, 4'b1111);
    ticks(3);
    check("rst_hold_o", r_o, 4'b0101);
    l_o     = 4'b0101;
    l_t     = 4'b1111;
    reset_n = 1'b1;
    ticks(5);
    check("idle_o", r_o, 4'b0101);

    // bit 0 falls, request returns at k+5, applied at k+1000
    l_o = 4'b0100;
    tick();
    check("b0_fall", r_o, 4'b0100);
    ticks(4);
    l_o = 4'b0101;
    ticks(995);
    check("b0_held", r_o & 4'b0001, 4'b0000);
    tick();
    check("b0_pend_apply", r_o & 4'b0001, 4'b0001);

    // bit 1 request bounces inside its hold window
    l_o = 4'b0111;
    tick();
    check("b1_rise", r_o & 4'b0010, 4'b0010);
    ticks(1000);
    l_o = 4'b0101;
    tick();
    check("b1_fall", r_o & 4'b0010, 4'b0000);
    ticks(10);
    l_o = 4'b0111;
    ticks(10);
    l_o = 4'b0101;
    ticks(978);
    check("b1_bounce_held", r_o & 4'b0010, 4'b0000);
    ticks(2);
    check("b1_expire", r_o & 4'b0010, 4'b0000);
    tick();
    check("b1_idle", r_o & 4'b0010, 4'b0000);

    // bits 2 and 3 together, with a coalesced return request
    l_o = 4'b1001;
    tick();
    check("b23_set", r_o, 4'b1001);
    l_o = 4'b0101;
    ticks(998);
    tick();
    check("b23_held", r_o, 4'b1001);
    tick();
    check("b23_apply", r_o, 4'b0101);

    // async reset at cycle 400 of a hold with a pending request
    l_o = 4'b0100;
    tick();
    check("rst_hold_start", r_o, 4'b0100);
    ticks(10);
    l_o = 4'b0101;
    ticks(389);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_o", r_o, 4'b0101);
    check("rst_mid_t", r_t, 4'b1111);
    ticks(2);
    l_o     = 4'b1010;
    l_t     = 4'b0011;
    reset_n = 1'b1;
    tick();
    check("rst_rel_o", r_o, 4'b1010);
    check("rst_rel_t", r_t, 4'b0011);

    // tristate follows with one register of latency while holds run
    l_t = 4'b0000;
    tick();
    check("tri_follow", r_t, 4'b0000);

    // random traffic
    repeat (40) begin
      l_o = 4'($urandom_range(0, 15));
      l_t = 4'($urandom_range(0, 15));
      ticks(int'($urandom_range(1, 300)));
    end
    ticks(1100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
